// File: rtl/vector_decode_seq.sv
// Registered decode stage: one 32-bit instruction in, one micro-op out for scalar ops,
// BEATS = VLEN_ELEMS/LANES micro-ops out for vector ops (one per lane group).
module vector_decode_seq #(
  parameter int XLEN       = 32,
  parameter int IMM_W      = 16,
  parameter int REG_AW     = 5,
  parameter int VLEN_ELEMS = 8,
  parameter int LANES      = 4,
  localparam int BEATS     = VLEN_ELEMS / LANES,
  localparam int BW        = $clog2(BEATS) + 1,
  localparam int EW        = $clog2(VLEN_ELEMS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic              uop_vec,
  output logic              uop_illegal,
  output logic [5:0]        uop_opcode,
  output logic [REG_AW-1:0] uop_rd,
  output logic [REG_AW-1:0] uop_rs1,
  output logic [REG_AW-1:0] uop_rs2,
  output logic [XLEN-1:0]   uop_imm,
  output logic [BW-1:0]     uop_beat,
  output logic [EW-1:0]     uop_elem_base,
  output logic              uop_last,
  output logic              dbg_state
);

  if (LANES < 1 || (VLEN_ELEMS % LANES) != 0) begin : g_bad_lanes
    $error("vector_decode_seq: LANES must divide VLEN_ELEMS");
  end

  // Handshakes: a transfer happens on a cycle where valid & ready are both high at the
  // rising edge; valid never depends on ready, and a presented uop holds until taken.
  typedef enum logic {EMPTY = 1'b0, ISSUE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              vec_q, ill_q;
  logic [5:0]        op_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]   imm_q;
  logic [BW-1:0]     beat_q;
  logic [EW-1:0]     eb_q;
  logic              last_beat, hs, accept;

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign uop_valid = (state_q == ISSUE);
  // Gated by valid so every uop_* output reads 0 out of reset.
  assign uop_last  = uop_valid & (~vec_q | ill_q | last_beat);
  assign hs        = uop_valid & uop_ready;
  assign in_ready  = rst_n & ~flush & ((state_q == EMPTY) | (hs & uop_last));
  assign accept    = in_valid & in_ready;

  assign uop_vec       = vec_q;
  assign uop_illegal   = ill_q;
  assign uop_opcode    = op_q;
  assign uop_rd        = rd_q;
  assign uop_rs1       = rs1_q;
  assign uop_rs2       = rs2_q;
  assign uop_imm       = imm_q;
  assign uop_beat      = beat_q;
  assign uop_elem_base = eb_q;
  assign dbg_state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                state_d = EMPTY;
    else if (accept)          state_d = ISSUE;
    else if (hs && uop_last)  state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= 1'b0;
      ill_q  <= 1'b0;
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      beat_q <= '0;
      eb_q   <= '0;
    end else if (flush) begin
      beat_q <= '0;
      eb_q   <= '0;
    end else if (accept) begin
      vec_q  <= in_instr[31];
      ill_q  <= (in_instr[31:30] == 2'b11);
      op_q   <= in_instr[31:26];
      rd_q   <= in_instr[21 +: REG_AW];
      rs1_q  <= in_instr[16 +: REG_AW];
      rs2_q  <= in_instr[11 +: REG_AW];
      imm_q  <= {{(XLEN-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
      beat_q <= '0;
      eb_q   <= '0;
    end else if (hs && !uop_last) begin
      // uop_last caps the count at BEATS-1, so it can never wrap.
      beat_q <= beat_q + BW'(1);
      eb_q   <= eb_q + EW'(LANES);
    end
  end

endmodule

// File: tb/tb_vector_decode_seq.sv
// Bench for vector_decode_seq: scenario tasks with inline checks plus a scoreboard
// that expands each accepted instruction into its expected micro-ops.
module tb_vector_decode_seq;

  localparam int XLEN = 32;
  localparam int BW   = 2;
  localparam int EW   = 4;
  localparam int UW   = 1 + 1 + 6 + 5 + 5 + 5 + XLEN + BW + EW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic            uop_valid;
  logic            uop_ready = 1'b0;
  logic            uop_vec, uop_illegal, uop_last, dbg_state;
  logic [5:0]      uop_opcode;
  logic [4:0]      uop_rd, uop_rs1, uop_rs2;
  logic [XLEN-1:0] uop_imm;
  logic [BW-1:0]   uop_beat;
  logic [EW-1:0]   uop_elem_base;

  int checks = 0;
  int errors = 0;
  logic [UW-1:0] exp_q[$];
  logic [UW-1:0] got;

  vector_decode_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vec(uop_vec), .uop_illegal(uop_illegal), .uop_opcode(uop_opcode),
    .uop_rd(uop_rd), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2), .uop_imm(uop_imm),
    .uop_beat(uop_beat), .uop_elem_base(uop_elem_base), .uop_last(uop_last),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  function automatic int n_beats(input logic [31:0] instr);
    return (instr[31] && !instr[30]) ? 2 : 1;
  endfunction

  function automatic logic [UW-1:0] exp_uop(input logic [31:0] instr, input int b);
    logic [XLEN-1:0] imm;
    logic            last;
    imm  = {{16{instr[15]}}, instr[15:0]};
    last = (b == n_beats(instr) - 1);
    return {instr[31], instr[31] & instr[30], instr[31:26], instr[25:21], instr[20:16],
            instr[15:11], imm, BW'(b), EW'(b * 4), last};
  endfunction

  function automatic logic [31:0] rand_instr(input logic [5:0] op);
    return {op, 26'($urandom())};
  endfunction

  assign got = {uop_vec, uop_illegal, uop_opcode, uop_rd, uop_rs1, uop_rs2, uop_imm,
                uop_beat, uop_elem_base, uop_last};

  // Scoreboard: pop on every uop handshake, push on every instruction accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (uop_valid && uop_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL uop_unexpected got %h exp none", got);
        end else begin
          logic [UW-1:0] e;
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL uop_content got %h exp %h", got, e);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        for (int b = 0; b < n_beats(in_instr); b++) exp_q.push_back(exp_uop(in_instr, b));
    end
  end

  task automatic send(input logic [31:0] instr);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_instr = instr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      uop_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got in_ready 0 exp 1");
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    uop_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (uop_valid !== 1'b0 || in_ready !== 1'b0 || uop_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got v%b r%b l%b exp v0 r0 l0", uop_valid, in_ready, uop_last);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || uop_beat !== '0 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got r%b beat%0d v%b exp r1 beat0 v0", in_ready, uop_beat, uop_valid);
    end
  endtask

  task automatic test_scalar_stream;
    @(posedge clk); #1;
    uop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_instr = rand_instr(6'h05);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL scalar_in_ready idx %0d got %b exp 1", i, in_ready);
      end
      if (i > 0) begin
        checks++;
        if (uop_valid !== 1'b1 || uop_last !== 1'b1) begin
          errors++;
          $display("FAIL scalar_stream idx %0d got v%b l%b exp v1 l1", i, uop_valid, uop_last);
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b1 || uop_last !== 1'b1) begin
      errors++;
      $display("FAIL scalar_tail got v%b l%b exp v1 l1", uop_valid, uop_last);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL scalar_drain got v%b exp 0", uop_valid);
    end
  endtask

  task automatic test_vector;
    @(posedge clk); #1;
    uop_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = rand_instr(6'h21);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b1 || uop_beat !== 2'd0 || uop_elem_base !== 4'd0 || uop_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL vector_beat0 got v%b b%0d e%0d l%b r%b exp v1 b0 e0 l0 r0",
               uop_valid, uop_beat, uop_elem_base, uop_last, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b1 || uop_beat !== 2'd1 || uop_elem_base !== 4'd4 || uop_last !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL vector_beat1 got v%b b%0d e%0d l%b r%b exp v1 b1 e4 l1 r1",
               uop_valid, uop_beat, uop_elem_base, uop_last, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL vector_done got v%b exp 0", uop_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] instr;
    instr = rand_instr(6'h2A);
    @(posedge clk); #1;
    uop_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (uop_valid !== 1'b1 || got !== exp_uop(instr, 0)) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v%b %h exp v1 %h", c, uop_valid, got, exp_uop(instr, 0));
      end
      @(posedge clk); #1;
    end
    uop_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (uop_beat !== 2'd0) begin
      errors++;
      $display("FAIL bp_release_beat got %0d exp 0", uop_beat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (uop_beat !== 2'd1 || uop_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_beat got b%0d v%b exp b1 v1", uop_beat, uop_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    uop_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = rand_instr(6'h21);
    @(posedge clk); #1;
    in_instr = rand_instr(6'h05);
    flush    = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || uop_valid !== 1'b1 || uop_beat !== 2'd0) begin
      errors++;
      $display("FAIL flush_cycle got r%b v%b b%0d exp r0 v1 b0", in_ready, uop_valid, uop_beat);
    end
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    uop_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL flush_after got v%b r%b s%b exp v0 r1 s0", uop_valid, in_ready, dbg_state);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (uop_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_beat cyc %0d got v%b exp 0", c, uop_valid);
      end
    end
  endtask

  task automatic test_illegal;
    @(posedge clk); #1;
    uop_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = {6'h35, 10'($urandom()), 16'h8001};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b1 || uop_illegal !== 1'b1 || uop_last !== 1'b1 || uop_imm !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL illegal_uop got v%b i%b l%b imm %h exp v1 i1 l1 imm ffff8001",
               uop_valid, uop_illegal, uop_last, uop_imm);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_single got v%b exp 0", uop_valid);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    uop_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = rand_instr(6'h3C & 6'h2F);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (uop_valid !== 1'b0 || in_ready !== 1'b0 || uop_beat !== '0 || uop_opcode !== '0) begin
      errors++;
      $display("FAIL reset_mid got v%b r%b b%0d op%h exp v0 r0 b0 op00",
               uop_valid, in_ready, uop_beat, uop_opcode);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    uop_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || uop_beat !== '0 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release got r%b b%0d v%b exp r1 b0 v0", in_ready, uop_beat, uop_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (uop_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_replay cyc %0d got v%b exp 0", c, uop_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops[4];
    ops[0] = 6'h05; ops[1] = 6'h21; ops[2] = 6'h35; ops[3] = 6'h1F;
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) send(rand_instr(ops[$urandom_range(0, 3)]));
    uop_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!uop_valid) break;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_scalar_stream;
    test_vector;
    test_backpressure;
    test_flush;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
